// File: rtl/button_event_queue.sv
// Converts debounced button levels into press events and queues them for the CPU.
// The CPU reads the head and status through q_data and pops it with rd_ack.
module button_event_queue #(
  parameter int NUM_BUTTONS = 4,
  parameter int DEPTH       = 8,
  parameter int PTR_W       = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic                   rd_ack,
  input  logic                   clr_ovf,
  output logic [31:0]            q_data,
  output logic                   ev_valid,
  output logic                   overflow
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [NUM_BUTTONS-1:0] prev;
  logic [NUM_BUTTONS-1:0] press_mask;
  logic [NUM_BUTTONS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;
  logic                   do_pop;
  logic                   do_push;
  logic                   do_drop;

  // prev tracks buttons even in reset so a button held through reset is not an event
  always_ff @(posedge clock) begin
    prev <= buttons;
  end

  always_comb begin
    press_mask = buttons & ~prev;
    do_pop     = rd_ack && (count != '0);
    do_push    = (press_mask != '0) && ((count < FULL_COUNT) || do_pop);
    do_drop    = (press_mask != '0) && !do_push;
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= press_mask;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (PTR_W+1)'(1);
      end
      // a drop in the same cycle as a clear leaves the flag set
      if (do_drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    q_data        = '0;
    q_data[31]    = (count != '0);
    q_data[30]    = overflow;
    q_data[29:24] = 6'(count);
    if (count != '0) begin
      q_data[NUM_BUTTONS-1:0] = mem[rd_ptr];
    end
    ev_valid = q_data[31];
  end

endmodule

// File: doc/button_event_queue.md
Name: button_event_queue

Overview:
- Input-direction counterpart to the processor's memory-mapped seven-segment output path.
- Turns debounced push-button levels into discrete press events and buffers them in a small FIFO.
- The processor polls the FIFO head with a load and consumes it with a read-acknowledge strobe generated by the memory-mapped I/O decode.
- Sits between the four Debouncer outputs and the processor's button input.

Parameters:
- NUM_BUTTONS, 4, number of button inputs; fixed at ≤ 16.
- DEPTH, 8, FIFO entries; power of two.
- PTR_W, 3, log2(DEPTH).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- buttons  in  NUM_BUTTONS  debounced button levels, already synchronous to clock; 1 = pressed.
- rd_ack  in  1  one-cycle pop strobe from the CPU load decode.
- clr_ovf  in  1  one-cycle strobe that clears the sticky overflow flag.
- q_data  out  32  status/event word presented to the CPU.
- ev_valid  out  1  FIFO non-empty; equals q_data[31].
- overflow  out  1  sticky overflow flag; equals q_data[30].

Behaviour:
- **Edge detect:**
  - prev register holds last-cycle buttons.
  - press_mask = buttons & ~prev.
  - prev <= buttons every cycle, including during reset, so a button held through reset produces no event.
- **Event formation:**
  - A nonzero press_mask in a cycle forms one event, written as the mask.
  - Several buttons rising in the same cycle give one entry with multiple bits set.
  - Release edges are ignored.
- **FIFO:**
  - Circular buffer of DEPTH entries × NUM_BUTTONS bits.
  - wr_ptr and rd_ptr are PTR_W bits and wrap DEPTH-1 -> 0.
  - count is PTR_W+1 bits, range 0..DEPTH.
- **Push:** when press_mask != 0:
  - If count < DEPTH, or a pop occurs in the same cycle: write mem[wr_ptr], advance wr_ptr.
  - Otherwise drop the event and set overflow.
- **Pop:** when rd_ack = 1 and count > 0, advance rd_ptr. rd_ack on an empty FIFO is ignored: no pointer change, no flag change.
- **Simultaneous push + pop:**
  - Both take effect and count is unchanged.
  - When full, no overflow.
  - When empty, the pop is ignored and the push succeeds (count 0 -> 1).
- **Overflow:** set by a dropped push; cleared by clr_ovf. If clr_ovf coincides with a new drop, overflow stays 1 (set wins).
- **q_data** is a combinational view of registered state:
  - [31] = count != 0.
  - [30] = overflow.
  - [29:24] = count, zero-extended.
  - [23:NUM_BUTTONS] = 0.
  - [NUM_BUTTONS-1:0] = mem[rd_ptr] when count != 0, else 0.
- **Latency:** a button rising before edge k is visible on q_data immediately after edge k (1 cycle). A pop at edge k exposes the next entry after edge k.
- **Reset:** whenever reset = 1 at a clock edge, regardless of activity in progress:
  - wr_ptr, rd_ptr, count = 0; overflow = 0.
  - Pushes and pops in that cycle are discarded.
  - q_data = 0, ev_valid = 0, overflow = 0 from the next cycle.
  - Memory contents need not be cleared.

Test Plan:
1. **Reset with held button:** assert reset 2 cycles with buttons = 4'b0001, release reset, hold buttons -> q_data stays 32'h0000_0000 (no event from the held button).
2. **Single/multi press:** buttons 0000 -> 0101 for 1 cycle -> next cycle q_data = 32'h8100_0005; rd_ack pulse -> q_data = 32'h0000_0000.
3. **Ordering and wrap:** 12 alternating press/pop rounds with masks 1,2,4,8,... -> each popped head matches the pushed order; pointers wrap past 7 with no loss.
4. **Overflow:**
   - 9 distinct presses, no pops -> count = 8, q_data = 32'hC800_0001 (first mask 1); the 9th event is absent from the pops.
   - clr_ovf -> bit 30 clears.
5. **Edge cases:**
   - While full, press + rd_ack in the same cycle -> overflow stays 0 and count stays 8.
   - While empty, press + rd_ack -> count = 1.
   - rd_ack when empty -> no change.
6. **Reset mid-operation:** with count = 5 and overflow = 1, assert reset coincident with a press -> next cycle q_data = 0, and the first post-reset press appears alone with count = 1.
